// File: rtl/pc_gen.sv
// Program-counter generator: boot cycle, sequential stepping (optionally compressed),
// prioritised trap/mret/branch redirects and a halt state for misaligned branch targets.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter bit              C_EXT        = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            instr_compressed_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            pc_valid_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] bad_addr_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Bits below IALIGN; any of them set in a branch target makes it misaligned.
  localparam logic [XLEN-1:0] LOW_BITS   = C_EXT ? {{(XLEN-1){1'b0}}, 1'b1}
                                                 : {{(XLEN-2){1'b0}}, 2'b11};
  localparam logic [XLEN-1:0] ALIGN_MASK = ~LOW_BITS;
  localparam logic [XLEN-1:0] STEP_2     = {{(XLEN-3){1'b0}}, 3'd2};
  localparam logic [XLEN-1:0] STEP_4     = {{(XLEN-3){1'b0}}, 3'd4};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic [XLEN-1:0] step_s;
  logic [XLEN-1:0] pc_plus_s;
  logic            target_misaligned_s;

  assign step_s              = (C_EXT && instr_compressed_i) ? STEP_2 : STEP_4;
  assign pc_plus_s           = pc_q + step_s;
  assign target_misaligned_s = ((branch_target_i & LOW_BITS) != {XLEN{1'b0}});

  // Next-state, next-PC and flag computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    bad_addr_d   = bad_addr_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trap_i) begin
          pc_d = trap_vector_i & ALIGN_MASK;
        end else if (mret_i) begin
          pc_d = epc_i & ALIGN_MASK;
        end else if (branch_taken_i && !target_misaligned_s) begin
          pc_d = branch_target_i;
        end else if (branch_taken_i) begin
          state_d      = ST_HALT;
          misaligned_d = 1'b1;
          bad_addr_d   = branch_target_i;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_plus_s;
        end
      end
      ST_HALT: begin
        if (trap_i) begin
          pc_d    = trap_vector_i & ALIGN_MASK;
          state_d = ST_RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
    pc_valid_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      pc_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      bad_addr_q   <= {XLEN{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      misaligned_q <= misaligned_d;
      bad_addr_q   <= bad_addr_d;
    end
  end

  assign pc_o         = pc_q;
  assign pc_plus_o    = pc_plus_s;
  assign pc_valid_o   = pc_valid_q;
  assign misaligned_o = misaligned_q;
  assign bad_addr_o   = bad_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with IALIGN=4 and one with compressed stepping.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;

  logic        stall_a, br_a, trap_a, mret_a, cmp_a;
  logic [31:0] tgt_a, vec_a, epc_a;
  logic [31:0] pc_a, plus_a, bad_a;
  logic        valid_a, mis_a;

  logic        stall_c, br_c, trap_c, mret_c, cmp_c;
  logic [31:0] tgt_c, vec_c, epc_c;
  logic [31:0] pc_c, plus_c, bad_c;
  logic        valid_c, mis_c;

  int n_cmp;
  int n_fail;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_a), .branch_taken_i(br_a),
    .branch_target_i(tgt_a), .trap_i(trap_a), .trap_vector_i(vec_a),
    .mret_i(mret_a), .epc_i(epc_a), .instr_compressed_i(cmp_a),
    .pc_o(pc_a), .pc_plus_o(plus_a), .pc_valid_o(valid_a),
    .misaligned_o(mis_a), .bad_addr_o(bad_a)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0100), .C_EXT(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_c), .branch_taken_i(br_c),
    .branch_target_i(tgt_c), .trap_i(trap_c), .trap_vector_i(vec_c),
    .mret_i(mret_c), .epc_i(epc_c), .instr_compressed_i(cmp_c),
    .pc_o(pc_c), .pc_plus_o(plus_c), .pc_valid_o(valid_c),
    .misaligned_o(mis_c), .bad_addr_o(bad_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    stall_a = 1'b0; br_a = 1'b0; trap_a = 1'b0; mret_a = 1'b0; cmp_a = 1'b0;
    tgt_a = 32'h0; vec_a = 32'h0; epc_a = 32'h0;
    stall_c = 1'b0; br_c = 1'b0; trap_c = 1'b0; mret_c = 1'b0; cmp_c = 1'b0;
    tgt_c = 32'h0; vec_c = 32'h0; epc_c = 32'h0;

    // Reset and boot
    tick(); tick();
    chk("rst_pc", pc_a, 32'h0000_1000);
    chk("rst_valid", {31'b0, valid_a}, 32'h0);
    chk("rst_mis", {31'b0, mis_a}, 32'h0);
    chk("rst_bad", bad_a, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("boot_pc", pc_a, 32'h0000_1000);
    chk("boot_valid", {31'b0, valid_a}, 32'h0);
    tick();
    chk("run0_pc", pc_a, 32'h0000_1000);
    chk("run0_valid", {31'b0, valid_a}, 32'h1);
    tick();
    chk("run1_pc", pc_a, 32'h0000_1004);
    tick();
    chk("run2_pc", pc_a, 32'h0000_1008);
    chk("run2_plus", plus_a, 32'h0000_100C);

    // Stall, then branch overriding stall
    br_a = 1'b1; tgt_a = 32'h20;
    tick();
    chk("br20_pc", pc_a, 32'h20);
    br_a = 1'b0; stall_a = 1'b1;
    tick();
    chk("stall1_pc", pc_a, 32'h20);
    tick();
    chk("stall2_pc", pc_a, 32'h20);
    br_a = 1'b1; tgt_a = 32'h80;
    tick();
    chk("br_over_stall", pc_a, 32'h80);

    // Priority: trap over mret over branch
    stall_a = 1'b0;
    trap_a = 1'b1; vec_a = 32'h200; mret_a = 1'b1; epc_a = 32'h44; br_a = 1'b1; tgt_a = 32'h300;
    tick();
    chk("prio_trap", pc_a, 32'h200);
    trap_a = 1'b0; br_a = 1'b0; epc_a = 32'h47;
    tick();
    chk("mret_mask", pc_a, 32'h44);
    mret_a = 1'b0;

    // Misaligned branch into HALT
    br_a = 1'b1; tgt_a = 32'h10;
    tick();
    chk("br10_pc", pc_a, 32'h10);
    tgt_a = 32'h102;
    tick();
    chk("mis_pc", pc_a, 32'h10);
    chk("mis_flag", {31'b0, mis_a}, 32'h1);
    chk("mis_bad", bad_a, 32'h102);
    chk("mis_valid", {31'b0, valid_a}, 32'h0);
    tgt_a = 32'h200; mret_a = 1'b1; epc_a = 32'h80;
    tick();
    chk("halt_pc", pc_a, 32'h10);
    chk("halt_flag", {31'b0, mis_a}, 32'h0);
    chk("halt_bad", bad_a, 32'h102);
    chk("halt_valid", {31'b0, valid_a}, 32'h0);
    br_a = 1'b0; mret_a = 1'b0; trap_a = 1'b1; vec_a = 32'h400;
    tick();
    chk("halt_trap_pc", pc_a, 32'h400);
    chk("halt_trap_valid", {31'b0, valid_a}, 32'h1);
    trap_a = 1'b0;

    // Async reset while halted
    br_a = 1'b1; tgt_a = 32'h501;
    tick();
    chk("mis2_flag", {31'b0, mis_a}, 32'h1);
    br_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_a, 32'h0000_1000);
    chk("arst_valid", {31'b0, valid_a}, 32'h0);
    chk("arst_bad", bad_a, 32'h0);
    chk("arst_mis", {31'b0, mis_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reboot_pc", pc_a, 32'h0000_1000);
    chk("reboot_valid", {31'b0, valid_a}, 32'h0);
    chk("c_boot_pc", pc_c, 32'h0000_0100);
    cmp_c = 1'b1;
    tick();
    chk("reboot_run_valid", {31'b0, valid_a}, 32'h1);
    chk("c_run_pc", pc_c, 32'h100);
    chk("c_plus2", plus_c, 32'h102);
    tick();
    chk("reboot_run1_pc", pc_a, 32'h0000_1004);
    chk("c_step2", pc_c, 32'h102);
    cmp_c = 1'b0;
    tick();
    chk("c_step4", pc_c, 32'h106);
    chk("c_plus4", plus_c, 32'h10A);

    // Compressed mode: half-word branch accepted, wrap at top of address space
    br_c = 1'b1; tgt_c = 32'h102;
    tick();
    chk("c_br_pc", pc_c, 32'h102);
    chk("c_br_mis", {31'b0, mis_c}, 32'h0);
    tgt_c = 32'hFFFF_FFFC;
    tick();
    chk("c_top_pc", pc_c, 32'hFFFF_FFFC);
    chk("c_wrap_plus", plus_c, 32'h0);
    br_c = 1'b0;
    tick();
    chk("c_wrap_pc", pc_c, 32'h0);
    br_c = 1'b1; tgt_c = 32'h103;
    tick();
    chk("c_mis_flag", {31'b0, mis_c}, 32'h1);
    chk("c_mis_bad", bad_c, 32'h103);
    chk("c_mis_pc", pc_c, 32'h0);
    br_c = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
